// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the carrier-recovery PLL sequencer.
package pll_seq_pkg;

    localparam int unsigned WDOG_W       = 8;
    localparam int unsigned LOOP_W       = 4;
    localparam int unsigned LOOP_LAT_DEF = 2;
    localparam int unsigned TIMEOUT_DEF  = 63;
    localparam int unsigned CNT_W_DEF    = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LAT  = 3'd1,
        S_VEC  = 3'd2,
        S_ROT  = 3'd3,
        S_LOOP = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    // Datapath strobes; at most one field is set in any cycle.
    typedef struct packed {
        logic lat_en;
        logic ce_vec;
        logic ce_rot;
        logic loop_start;
        logic phi_we;
    } strobe_t;

    // States in which the sequencer waits on a CORDIC ready pulse.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_VEC) || (s == S_ROT);
    endfunction

endpackage

// File: rtl/pll_seq_wdog.sv
// Wait-state watchdog: counts cycles spent in a CORDIC wait state and flags
// the cycle in which the TIMEOUT-th wait cycle is reached.
module pll_seq_wdog
    import pll_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired_c
);

    logic [WDOG_W-1:0] wait_cnt;

    // Count of wait cycles already completed before the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (run && !expired_c) begin
            wait_cnt <= wait_cnt + WDOG_W'(1);
        end
    end

    assign expired_c = run && (wait_cnt == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: sequences latch -> vectoring CORDIC -> rotation CORDIC ->
// loop filter for one I/Q sample per handshake and owns the phi feedback
// write enable. Optional watchdog on the CORDIC waits: define PLL_SEQ_WDOG_EN.
module pll_seq_ctrl
    import pll_seq_pkg::*;
#(
    parameter int unsigned LOOP_LAT = LOOP_LAT_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             lat_en,
    output logic             ce_vec,
    input  logic             ready_vec,
    output logic             ce_rot,
    input  logic             ready_rot,
    output logic             loop_start,
    output logic             phi_we,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             err_spur,
    output logic             err_timeout
);

    // Elaboration-time parameter range guards.
    if (LOOP_LAT < 1 || LOOP_LAT > 15) begin : g_bad_loop_lat
        $error("pll_seq_ctrl: LOOP_LAT must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("pll_seq_ctrl: TIMEOUT must be 1..255");
    end

    state_t             state, state_nxt;
    strobe_t            strb, strb_nxt;
    logic [LOOP_W-1:0]  loop_cnt, loop_cnt_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               err_spur_nxt;

`ifdef PLL_SEQ_WDOG_EN
    logic               wdog_expired_c;
    logic               err_timeout_nxt;

    // Watchdog restarts whenever a CORDIC stage is started.
    pll_seq_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clr       (strb_nxt.ce_vec | strb_nxt.ce_rot),
        .run       (is_wait_state(state)),
        .expired_c (wdog_expired_c)
    );
`endif

    assign lat_en     = strb.lat_en;
    assign ce_vec     = strb.ce_vec;
    assign ce_rot     = strb.ce_rot;
    assign loop_start = strb.loop_start;
    assign phi_we     = strb.phi_we;

    // Next state, next strobes and sticky error flags.
    always_comb begin
        state_nxt    = state;
        strb_nxt     = '0;
        loop_cnt_nxt = loop_cnt;
        cnt_nxt      = sample_cnt;
        err_spur_nxt = err_spur;
`ifdef PLL_SEQ_WDOG_EN
        err_timeout_nxt = err_timeout;
`endif

        // A ready is only honoured in its own wait state after the start cycle.
        if (ready_vec && !(state == S_VEC && !strb.ce_vec)) begin
            err_spur_nxt = 1'b1;
        end
        if (ready_rot && !(state == S_ROT && !strb.ce_rot)) begin
            err_spur_nxt = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt       = S_LAT;
                    strb_nxt.lat_en = 1'b1;
                end
            end
            S_LAT: begin
                state_nxt       = S_VEC;
                strb_nxt.ce_vec = 1'b1;
            end
            S_VEC: begin
                if (ready_vec && !strb.ce_vec) begin
                    state_nxt       = S_ROT;
                    strb_nxt.ce_rot = 1'b1;
                end
`ifdef PLL_SEQ_WDOG_EN
                else if (wdog_expired_c) begin
                    state_nxt       = S_IDLE;
                    err_timeout_nxt = 1'b1;
                end
`endif
            end
            S_ROT: begin
                if (ready_rot && !strb.ce_rot) begin
                    state_nxt           = S_LOOP;
                    strb_nxt.loop_start = 1'b1;
                    loop_cnt_nxt        = LOOP_W'(LOOP_LAT - 1);
                end
`ifdef PLL_SEQ_WDOG_EN
                else if (wdog_expired_c) begin
                    state_nxt       = S_IDLE;
                    err_timeout_nxt = 1'b1;
                end
`endif
            end
            S_LOOP: begin
                if (strb.phi_we) begin
                    state_nxt = S_OUT;
                end else if (loop_cnt == '0) begin
                    strb_nxt.phi_we = 1'b1;
                end else begin
                    loop_cnt_nxt = loop_cnt - LOOP_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = sample_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, strobe and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            strb       <= '0;
            loop_cnt   <= '0;
            sample_cnt <= '0;
            err_spur   <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            strb       <= strb_nxt;
            loop_cnt   <= loop_cnt_nxt;
            sample_cnt <= cnt_nxt;
            err_spur   <= err_spur_nxt;
            in_ready   <= (state_nxt == S_IDLE);
            busy       <= (state_nxt != S_IDLE);
            out_valid  <= (state_nxt == S_OUT);
        end
    end

`ifdef PLL_SEQ_WDOG_EN
    // Sticky watchdog abort flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= err_timeout_nxt;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed self-checking bench for pll_seq_ctrl (LOOP_LAT=2, TIMEOUT=63, CNT_W=4).
module tb_pll_seq_ctrl;

    localparam int unsigned CNT_W  = 4;
    localparam int          BUDGET = 200;

    logic             clk = 1'b0;
    logic             rst, in_valid, ready_vec, ready_rot, out_ready;
    logic             in_ready, lat_en, ce_vec, ce_rot, loop_start, phi_we;
    logic             out_valid, busy, err_spur, err_timeout;
    logic [CNT_W-1:0] sample_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    // Monitor counters: pulse cycle counts and time of last occurrence.
    int cyc = 0;
    int n_lat = 0, n_vec = 0, n_rot = 0, n_loop = 0, n_phi = 0, n_out = 0, n_multi = 0;
    int t_lat = 0, t_vec = 0, t_rot = 0, t_loop = 0, t_phi = 0, t_out = 0;
    int b_lat, b_vec, b_rot, b_loop, b_phi, b_out;
    int held;

    pll_seq_ctrl #(
        .LOOP_LAT (2),
        .TIMEOUT  (63),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lat_en      (lat_en),
        .ce_vec      (ce_vec),
        .ready_vec   (ready_vec),
        .ce_rot      (ce_rot),
        .ready_rot   (ready_rot),
        .loop_start  (loop_start),
        .phi_we      (phi_we),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .sample_cnt  (sample_cnt),
        .err_spur    (err_spur),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Per-cycle pulse bookkeeping, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (lat_en)     begin n_lat  <= n_lat + 1;  t_lat  <= cyc; end
        if (ce_vec)     begin n_vec  <= n_vec + 1;  t_vec  <= cyc; end
        if (ce_rot)     begin n_rot  <= n_rot + 1;  t_rot  <= cyc; end
        if (loop_start) begin n_loop <= n_loop + 1; t_loop <= cyc; end
        if (phi_we)     begin n_phi  <= n_phi + 1;  t_phi  <= cyc; end
        if (out_valid)  begin n_out  <= n_out + 1;  t_out  <= cyc; end
        if ($countones({lat_en, ce_vec, ce_rot, loop_start, phi_we}) > 1)
            n_multi <= n_multi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return ce_vec;
            1:       return ce_rot;
            default: return out_valid;
        endcase
    endfunction

    // Advance falling edges until the selected output is high, bounded.
    task automatic wait_for(input int sel, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < BUDGET && !hit; i++) begin
            if (sig_of(sel)) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) check(tag, 32'(hit), 32'd1);
    endtask

    task automatic snapshot();
        b_lat = n_lat; b_vec = n_vec; b_rot = n_rot;
        b_loop = n_loop; b_phi = n_phi; b_out = n_out;
    endtask

    // Offer a sample from an idle cycle; returns in the latch cycle.
    task automatic start_sample(input bit hold);
        in_valid = 1'b1;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    // Answer the CORDIC stages vd/rd cycles after their start; returns when out_valid.
    task automatic finish_sample(input int vd, input int rd);
        wait_for(0, "wait_ce_vec");
        repeat (vd) @(negedge clk);
        ready_vec = 1'b1;
        @(negedge clk);
        ready_vec = 1'b0;
        wait_for(1, "wait_ce_rot");
        repeat (rd) @(negedge clk);
        ready_rot = 1'b1;
        @(negedge clk);
        ready_rot = 1'b0;
        wait_for(2, "wait_out_valid");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; ready_vec = 1'b0; ready_rot = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // 1: reset state
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_pulses", 32'({lat_en, ce_vec, ce_rot, loop_start, phi_we, out_valid}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(sample_cnt), 0);
        check("rst_err", 32'({err_spur, err_timeout}), 0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 1);
        check("idle_busy", 32'(busy), 0);

        // 2: nominal sample, vec 5 / rot 4 cycles after start
        snapshot();
        start_sample(1'b0);
        check("nom_lat_busy", 32'({lat_en, busy, in_ready}), 32'b110);
        finish_sample(5, 4);
        @(negedge clk);
        exp_cnt++;
        check("nom_cnt", 32'(sample_cnt), 32'(exp_cnt % 16));
        check("nom_idle", 32'({in_ready, out_valid}), 32'b10);
        @(negedge clk);
        check("nom_n_pulses", 32'({4'(n_lat - b_lat), 4'(n_vec - b_vec), 4'(n_rot - b_rot),
                                   4'(n_loop - b_loop), 4'(n_phi - b_phi), 4'(n_out - b_out)}),
              32'h111111);
        check("nom_vec_after_lat", 32'(t_vec - t_lat), 1);
        check("nom_rot_after_vec", 32'(t_rot - t_vec), 6);
        check("nom_loop_after_rot", 32'(t_loop - t_rot), 5);
        check("nom_phi_after_loop", 32'(t_phi - t_loop), 2);
        check("nom_out_after_phi", 32'(t_out - t_phi), 1);

        // 3: output backpressure with in_valid held
        out_ready = 1'b0;
        snapshot();
        start_sample(1'b1);
        finish_sample(3, 2);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && !in_ready) held++;
            @(negedge clk);
        end
        check("bp_held", 32'(held), 10);
        check("bp_single_lat", 32'(n_lat - b_lat), 1);
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        check("bp_release_idle", 32'({in_ready, out_valid}), 32'b10);
        check("bp_cnt", 32'(sample_cnt), 32'(exp_cnt % 16));
        @(negedge clk);
        check("bp_second_accept", 32'(lat_en), 1);
        in_valid = 1'b0;
        finish_sample(2, 2);
        @(negedge clk);
        exp_cnt++;
        check("bp_cnt2", 32'(sample_cnt), 32'(exp_cnt % 16));

        // 4: spurious readies
        check("spur_clear", 32'(err_spur), 0);
        snapshot();
        start_sample(1'b0);
        wait_for(0, "spur_wait_vec");
        ready_vec = 1'b1;
        @(negedge clk);
        ready_vec = 1'b0; ready_rot = 1'b1;
        @(negedge clk);
        ready_rot = 1'b0;
        check("spur_flag", 32'(err_spur), 1);
        check("spur_stay_vec", 32'({ce_rot, busy}), 32'b01);
        check("spur_no_rot", 32'(n_rot - b_rot), 0);
        ready_vec = 1'b1;
        @(negedge clk);
        ready_vec = 1'b0;
        wait_for(1, "spur_wait_rot");
        repeat (2) @(negedge clk);
        ready_rot = 1'b1;
        @(negedge clk);
        ready_rot = 1'b0;
        wait_for(2, "spur_wait_out");
        @(negedge clk);
        exp_cnt++;
        check("spur_cnt", 32'(sample_cnt), 32'(exp_cnt % 16));
        check("spur_sticky", 32'(err_spur), 1);
        check("spur_rot_after_vec", 32'(t_rot - t_vec), 3);

        // 5: CORDIC never answers
        snapshot();
        start_sample(1'b0);
        wait_for(0, "wd_wait_vec");
`ifdef PLL_SEQ_WDOG_EN
        repeat (62) @(negedge clk);
        check("wd_busy_before", 32'(busy), 1);
        @(negedge clk);
        check("wd_idle", 32'({in_ready, busy}), 32'b10);
        check("wd_flag", 32'(err_timeout), 1);
        @(negedge clk);
        check("wd_no_phi", 32'(n_phi - b_phi), 0);
        check("wd_cnt", 32'(sample_cnt), 32'(exp_cnt % 16));
`else
        repeat (100) @(negedge clk);
        check("nowd_busy", 32'({busy, in_ready}), 32'b10);
        check("nowd_flag", 32'(err_timeout), 0);
        check("nowd_no_phi", 32'(n_phi - b_phi), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        check("nowd_rst_spur", 32'(err_spur), 0);
`endif

        // 6a: reset during rotation wait
        snapshot();
        start_sample(1'b0);
        wait_for(0, "rm_wait_vec");
        repeat (2) @(negedge clk);
        ready_vec = 1'b1;
        @(negedge clk);
        ready_vec = 1'b0;
        wait_for(1, "rm_wait_rot");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        check("rm_idle", 32'({in_ready, busy}), 32'b10);
        check("rm_cnt", 32'(sample_cnt), 0);
        check("rm_err", 32'({err_spur, err_timeout}), 0);
        repeat (5) @(negedge clk);
        check("rm_no_loop_phi", 32'({4'(n_loop - b_loop), 4'(n_phi - b_phi)}), 0);

        // 6b: 16 samples wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            start_sample(1'b0);
            finish_sample(1 + i % 3, 1 + i % 4);
            @(negedge clk);
            exp_cnt++;
            if (i == 14) check("wrap_15", 32'(sample_cnt), 15);
        end
        check("wrap_0", 32'(sample_cnt), 32'(exp_cnt % 16));

        repeat (2) @(negedge clk);
        check("onehot_strobes", 32'(n_multi), 0);
        check("phi_total", 32'(n_phi), 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
